// File: rtl/model_vector_summation_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | model_vector_summation_buffered                                            |
// | Element-wise sum of LENGTH_IN vectors into a buffer, streamed out by index.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module model_vector_summation_buffered #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_SIZE     = 16,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    DATA_IN_ENABLE,
  output logic                    DATA_OUT_SCALAR_ENABLE,
  output logic                    DATA_OUT_VECTOR_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    OVERFLOW,
  output logic                    ERROR
);

  localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
  localparam logic [CONTROL_SIZE-1:0] C_ONE = CONTROL_SIZE'(1);
  localparam logic [CONTROL_SIZE-1:0] C_MAX = CONTROL_SIZE'(MAX_SIZE);
  localparam logic [DATA_SIZE-1:0] C_POS_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] C_NEG_MAX = {1'b1, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  logic [CONTROL_SIZE-1:0] size_q;
  logic [CONTROL_SIZE-1:0] len_q;
  logic [CONTROL_SIZE-1:0] e_q;
  logic [CONTROL_SIZE-1:0] v_q;
  logic                    ready_q;
  logic                    scalar_en_q;
  logic                    vector_en_q;
  logic [DATA_SIZE-1:0]    dout_q;
  logic                    ovf_q;
  logic                    err_q;
  logic [DATA_SIZE-1:0]    acc_q [MAX_SIZE];

  logic [IDX_W-1:0]        idx;
  logic [DATA_SIZE-1:0]    acc_rd;
  logic [DATA_SIZE-1:0]    add_sum;
  logic                    add_ovf;
  logic [DATA_SIZE-1:0]    acc_d;
  logic                    acc_we;
  logic                    e_last;
  logic                    v_last;
  logic                    cfg_bad;

  always_comb begin
    idx     = e_q[IDX_W-1:0];
    acc_rd  = acc_q[idx];
    add_sum = acc_rd + DATA_IN;
    // Overflow only possible when both operands share a sign and the sum flips it
    add_ovf = (acc_rd[DATA_SIZE-1] == DATA_IN[DATA_SIZE-1]) &&
              (add_sum[DATA_SIZE-1] != acc_rd[DATA_SIZE-1]);
    acc_d   = add_sum;
    if (v_q == '0) begin
      acc_d = DATA_IN;
    end else if (SATURATE && add_ovf) begin
      acc_d = acc_rd[DATA_SIZE-1] ? C_NEG_MAX : C_POS_MAX;
    end
    acc_we  = (state_q == S_ACC) && DATA_IN_ENABLE;
    e_last  = (e_q == size_q - C_ONE);
    v_last  = (v_q == len_q - C_ONE);
    cfg_bad = (SIZE_IN == '0) || (SIZE_IN > C_MAX) || (LENGTH_IN == '0);
  end

  // The first vector overwrites each slot, so the buffer needs no reset
  always_ff @(posedge CLK) begin
    if (acc_we) begin
      acc_q[idx] <= acc_d;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      len_q       <= '0;
      e_q         <= '0;
      v_q         <= '0;
      ready_q     <= 1'b0;
      scalar_en_q <= 1'b0;
      vector_en_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= 1'b0;
      scalar_en_q <= 1'b0;
      vector_en_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            if (cfg_bad) begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
            end else begin
              size_q  <= SIZE_IN;
              len_q   <= LENGTH_IN;
              e_q     <= '0;
              v_q     <= '0;
              ovf_q   <= 1'b0;
              state_q <= S_ACC;
            end
          end
        end
        S_ACC: begin
          if (DATA_IN_ENABLE) begin
            if ((v_q != '0) && add_ovf) begin
              ovf_q <= 1'b1;
            end
            if (e_last) begin
              e_q <= '0;
              if (v_last) begin
                state_q <= S_DRAIN;
              end else begin
                v_q <= v_q + C_ONE;
              end
            end else begin
              e_q <= e_q + C_ONE;
            end
          end
        end
        S_DRAIN: begin
          scalar_en_q <= 1'b1;
          dout_q      <= acc_rd;
          if (e_last) begin
            vector_en_q <= 1'b1;
            ready_q     <= 1'b1;
            e_q         <= '0;
            state_q     <= S_IDLE;
          end else begin
            e_q <= e_q + C_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign READY                  = ready_q;
  assign DATA_OUT_SCALAR_ENABLE = scalar_en_q;
  assign DATA_OUT_VECTOR_ENABLE = vector_en_q;
  assign DATA_OUT               = dout_q;
  assign OVERFLOW               = ovf_q;
  assign ERROR                  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_model_vector_summation_buffered.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_model_vector_summation_buffered                                         |
// | Directed bench: 64-bit saturating, 8-bit saturating and 8-bit wrapping DUTs|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_model_vector_summation_buffered;

  localparam int DW = 64;
  localparam int CW = 64;
  localparam int MS = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          DATA_IN_ENABLE;
  logic [CW-1:0] SIZE_IN;
  logic [CW-1:0] LENGTH_IN;
  logic [DW-1:0] DATA_IN;

  logic          m_ready, m_scal, m_vec, m_ovf, m_err;
  logic [63:0]   m_dout;
  logic          s_ready, s_scal, s_vec, s_ovf, s_err;
  logic [7:0]    s_dout;
  logic          w_ready, w_scal, w_vec, w_ovf, w_err;
  logic [7:0]    w_dout;

  always #5 CLK = ~CLK;

  model_vector_summation_buffered #(
    .DATA_SIZE(64), .CONTROL_SIZE(CW), .MAX_SIZE(MS), .SATURATE(1'b1)
  ) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(m_ready),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_OUT_SCALAR_ENABLE(m_scal),
    .DATA_OUT_VECTOR_ENABLE(m_vec), .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN),
    .DATA_IN(DATA_IN), .DATA_OUT(m_dout), .OVERFLOW(m_ovf), .ERROR(m_err)
  );

  model_vector_summation_buffered #(
    .DATA_SIZE(8), .CONTROL_SIZE(CW), .MAX_SIZE(MS), .SATURATE(1'b1)
  ) u_sat8 (
    .CLK(CLK), .RST(RST), .START(START), .READY(s_ready),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_OUT_SCALAR_ENABLE(s_scal),
    .DATA_OUT_VECTOR_ENABLE(s_vec), .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN),
    .DATA_IN(DATA_IN[7:0]), .DATA_OUT(s_dout), .OVERFLOW(s_ovf), .ERROR(s_err)
  );

  model_vector_summation_buffered #(
    .DATA_SIZE(8), .CONTROL_SIZE(CW), .MAX_SIZE(MS), .SATURATE(1'b0)
  ) u_wrap8 (
    .CLK(CLK), .RST(RST), .START(START), .READY(w_ready),
    .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_OUT_SCALAR_ENABLE(w_scal),
    .DATA_OUT_VECTOR_ENABLE(w_vec), .SIZE_IN(SIZE_IN), .LENGTH_IN(LENGTH_IN),
    .DATA_IN(DATA_IN[7:0]), .DATA_OUT(w_dout), .OVERFLOW(w_ovf), .ERROR(w_err)
  );

  typedef logic [0:7][15:0] vin_t;
  typedef logic [0:3][15:0] vout_t;
  typedef struct packed {
    int    size;
    int    len;
    bit    gaps;
    bit    poke;
    vin_t  din;
    vout_t e64;
    vout_t es8;
    vout_t ew8;
    bit    o64;
    bit    os8;
    bit    ow8;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          run_id   = 0;
  logic [63:0] g_din [48];
  logic [63:0] g_e64 [16];
  logic [7:0]  g_es  [16];
  logic [7:0]  g_ew  [16];
  bit          g_o64, g_os, g_ow;
  vec_t        tbl [5];

  function automatic vin_t p8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {a0[15:0], a1[15:0], a2[15:0], a3[15:0], a4[15:0], a5[15:0], a6[15:0], a7[15:0]};
  endfunction

  function automatic vout_t p4(input int a0, a1, a2, a3);
    return {a0[15:0], a1[15:0], a2[15:0], a3[15:0]};
  endfunction

  function automatic vec_t mk(input int size, len, input bit gaps, poke, input vin_t din,
                              input vout_t e64, es8, ew8, input bit o64, os8, ow8);
    vec_t r;
    r.size = size; r.len = len; r.gaps = gaps; r.poke = poke; r.din = din;
    r.e64 = e64; r.es8 = es8; r.ew8 = ew8; r.o64 = o64; r.os8 = os8; r.ow8 = ow8;
    return r;
  endfunction

  function automatic logic [63:0] sx8(input logic [7:0] x);
    return {{56{x[7]}}, x};
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input vec_t r);
    for (int i = 0; i < 8; i++) g_din[i] = {{48{r.din[i][15]}}, r.din[i]};
    for (int i = 0; i < 4; i++) begin
      g_e64[i] = {{48{r.e64[i][15]}}, r.e64[i]};
      g_es[i]  = r.es8[i][7:0];
      g_ew[i]  = r.ew8[i][7:0];
    end
    g_o64 = r.o64; g_os = r.os8; g_ow = r.ow8;
  endtask

  // Called at a negedge; returns at the negedge where READY is visible.
  task automatic run(input int size, input int len, input bit gaps, input bit poke);
    int n;
    int i;
    int gapc;
    n    = size * len;
    i    = 0;
    gapc = 0;
    run_id++;
    START = 1'b1; SIZE_IN = CW'(size); LENGTH_IN = CW'(len); DATA_IN_ENABLE = 1'b0;
    @(negedge CLK);
    START = 1'b0; SIZE_IN = '0; LENGTH_IN = '0;
    chk($sformatf("r%0d_start_ready", run_id), m_ready, 0);
    chk($sformatf("r%0d_start_scal", run_id), m_scal, 0);
    chk($sformatf("r%0d_start_ovf", run_id), {m_ovf, s_ovf, w_ovf}, 0);
    chk($sformatf("r%0d_start_err", run_id), m_err, 0);
    while (i < n) begin
      if (gaps && gapc < 64 && $urandom_range(0, 1) == 1) begin
        DATA_IN_ENABLE = 1'b0;
        DATA_IN = {$urandom, $urandom};
        gapc++;
      end else begin
        DATA_IN_ENABLE = 1'b1;
        DATA_IN = g_din[i];
        i++;
      end
      START = poke && (i == 2);
      @(negedge CLK);
      chk($sformatf("r%0d_acc_quiet", run_id), {m_scal, m_ready, m_err, m_vec}, 0);
    end
    DATA_IN_ENABLE = poke;
    DATA_IN = 64'h0000_0000_0000_005A;
    START = poke;
    for (int e = 0; e < size; e++) begin
      @(negedge CLK);
      START = 1'b0;
      chk($sformatf("r%0d_e%0d_scal", run_id, e), m_scal, 1);
      chk($sformatf("r%0d_e%0d_vec", run_id, e), m_vec, (e == size - 1) ? 1 : 0);
      chk($sformatf("r%0d_e%0d_ready", run_id, e), m_ready, (e == size - 1) ? 1 : 0);
      chk($sformatf("r%0d_e%0d_err", run_id, e), {m_err, s_err, w_err}, 0);
      chk($sformatf("r%0d_e%0d_d64", run_id, e), m_dout, g_e64[e]);
      chk($sformatf("r%0d_e%0d_sat8", run_id, e), sx8(s_dout), sx8(g_es[e]));
      chk($sformatf("r%0d_e%0d_wrap8", run_id, e), sx8(w_dout), sx8(g_ew[e]));
    end
    DATA_IN_ENABLE = 1'b0;
    chk($sformatf("r%0d_ovf64", run_id), m_ovf, g_o64);
    chk($sformatf("r%0d_ovf_sat8", run_id), s_ovf, g_os);
    chk($sformatf("r%0d_ovf_wrap8", run_id), w_ovf, g_ow);
  endtask

  task automatic err_start(input int size, input int len);
    START = 1'b1; SIZE_IN = CW'(size); LENGTH_IN = CW'(len);
    @(negedge CLK);
    START = 1'b0;
    chk($sformatf("err_s%0d_l%0d_err", size, len), m_err, 1);
    chk($sformatf("err_s%0d_l%0d_ready", size, len), m_ready, 1);
    chk($sformatf("err_s%0d_l%0d_scal", size, len), m_scal, 0);
    @(negedge CLK);
    chk($sformatf("err_s%0d_l%0d_pulse", size, len), {m_err, m_ready, m_scal}, 0);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; DATA_IN_ENABLE = 1'b0;
    SIZE_IN = '0; LENGTH_IN = '0; DATA_IN = '0;

    tbl[0] = mk(3, 2, 0, 0, p8(1, 2, 3, 4, 5, 6, 0, 0),
                p4(5, 7, 9, 0), p4(5, 7, 9, 0), p4(5, 7, 9, 0), 0, 0, 0);
    tbl[1] = mk(4, 1, 1, 1, p8(10, -3, 0, 7, 0, 0, 0, 0),
                p4(10, -3, 0, 7), p4(10, -3, 0, 7), p4(10, -3, 0, 7), 0, 0, 0);
    tbl[2] = mk(2, 2, 0, 0, p8(100, -100, 100, -100, 0, 0, 0, 0),
                p4(200, -200, 0, 0), p4(127, -128, 0, 0), p4(-56, 56, 0, 0), 0, 1, 1);
    tbl[3] = mk(1, 2, 0, 0, p8(50, 50, 0, 0, 0, 0, 0, 0),
                p4(100, 0, 0, 0), p4(100, 0, 0, 0), p4(100, 0, 0, 0), 0, 0, 0);
    tbl[4] = mk(2, 3, 1, 0, p8(127, -128, 1, -1, 0, 0, 0, 0),
                p4(128, -129, 0, 0), p4(127, -128, 0, 0), p4(-128, 127, 0, 0), 0, 1, 1);

    repeat (2) @(negedge CLK);
    chk("reset_outputs", {m_ready, m_scal, m_vec, m_ovf, m_err}, 0);
    chk("reset_dout", m_dout, 0);
    chk("reset_dout8", {s_dout, w_dout}, 0);
    RST = 1'b1;

    // Back-to-back table runs: each START lands in the previous READY cycle
    for (int t = 0; t < 5; t++) begin
      load(tbl[t]);
      run(tbl[t].size, tbl[t].len, tbl[t].gaps, tbl[t].poke);
    end

    err_start(0, 1);
    err_start(MS + 1, 1);
    err_start(4, 0);

    for (int i = 0; i < 48; i++) g_din[i] = 64'd1;
    for (int i = 0; i < 16; i++) begin
      g_e64[i] = 64'd3; g_es[i] = 8'd3; g_ew[i] = 8'd3;
    end
    g_o64 = 0; g_os = 0; g_ow = 0;
    run(MS, 3, 0, 0);

    // Abandon a run partway through accumulation
    START = 1'b1; SIZE_IN = CW'(3); LENGTH_IN = CW'(2);
    @(negedge CLK);
    START = 1'b0; DATA_IN_ENABLE = 1'b1; DATA_IN = 64'd7;
    @(negedge CLK);
    DATA_IN = 64'd8;
    @(negedge CLK);
    DATA_IN_ENABLE = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("midrst_outputs", {m_ready, m_scal, m_vec, m_ovf, m_err}, 0);
    chk("midrst_dout", m_dout, 0);
    @(negedge CLK);
    chk("midrst_hold", {m_ready, m_scal, m_vec, m_err, s_scal, w_scal}, 0);
    chk("midrst_dout8", {s_dout, w_dout}, 0);
    RST = 1'b1;

    g_din[0] = 64'd1; g_din[1] = 64'd1; g_din[2] = 64'd2; g_din[3] = 64'd2;
    g_e64[0] = 64'd3; g_e64[1] = 64'd3;
    g_es[0] = 8'd3; g_es[1] = 8'd3; g_ew[0] = 8'd3; g_ew[1] = 8'd3;
    g_o64 = 0; g_os = 0; g_ow = 0;
    run(2, 2, 0, 1);

    @(negedge CLK);
    chk("final_idle", {m_scal, m_vec, m_ready, m_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/model_vector_summation_buffered.md
# model_vector_summation_buffered

Parametrised element-wise vector accumulator for the NTM algebra library: sums LENGTH_IN input vectors of SIZE_IN elements each, stored in an internal MAX_SIZE-deep accumulator buffer, then streams the SIZE_IN result elements out one per cycle. Signed two's-complement integer arithmetic with selectable saturate/wrap overflow handling and a sticky overflow flag. It sits beside the other vector-algebra blocks and feeds the memory/controller datapaths that consume streamed vectors.

## Interface

- DATA_SIZE, 64, element width in bits, signed two's-complement
- CONTROL_SIZE, 64, width of SIZE_IN/LENGTH_IN and internal indices
- MAX_SIZE, 16, accumulator buffer depth, i.e. largest legal SIZE_IN
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^DATA_SIZE

- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- START  in  1  begin a run; sampled only in IDLE
- READY  out  1  one-cycle pulse at end of run (normal or error)
- DATA_IN_ENABLE  in  1  DATA_IN valid this cycle
- DATA_OUT_SCALAR_ENABLE  out  1  DATA_OUT holds a result element
- DATA_OUT_VECTOR_ENABLE  out  1  pulse with last result element
- SIZE_IN  in  CONTROL_SIZE  elements per vector, latched at START
- LENGTH_IN  in  CONTROL_SIZE  number of vectors, latched at START
- DATA_IN  in  DATA_SIZE  input element
- DATA_OUT  out  DATA_SIZE  result element
- OVERFLOW  out  1  sticky: any add overflowed during the run
- ERROR  out  1  one-cycle pulse: illegal SIZE_IN/LENGTH_IN

## Operation

- States: IDLE, ACCUMULATE, DRAIN.
- IDLE: on START=1 latch SIZE_IN, LENGTH_IN; clear OVERFLOW, element index e, vector index v.
  - SIZE_IN=0, SIZE_IN>MAX_SIZE or LENGTH_IN=0: ERROR=1 and READY=1 for one cycle, stay IDLE, no output.
  - Otherwise go to ACCUMULATE.
- ACCUMULATE: each cycle with DATA_IN_ENABLE=1 accepts one element, input order vector-major (v0 e0..eS-1, v1 e0..). acc[e] <= DATA_IN if v=0, else add(acc[e], DATA_IN). e increments, wraps to 0 at SIZE-1 with v incrementing. Gaps (enable low) stall indefinitely. Accepting (e=SIZE-1, v=LENGTH-1) moves to DRAIN with e=0.
- add: full-width signed sum; overflow when operand signs equal and result sign differs. SATURATE=1 → +2^(DATA_SIZE-1)-1 or -2^(DATA_SIZE-1); SATURATE=0 → low DATA_SIZE bits. Any overflow sets OVERFLOW until next accepted START.
- DRAIN: one element per cycle, DATA_OUT=acc[e], DATA_OUT_SCALAR_ENABLE=1. On e=SIZE-1 also DATA_OUT_VECTOR_ENABLE=1 and READY=1, return to IDLE. No backpressure.
- START ignored outside IDLE; DATA_IN_ENABLE ignored outside ACCUMULATE.
- Buffer contents never need reset: v=0 overwrites.

## Timing

- Reset values: READY=0, DATA_OUT_SCALAR_ENABLE=0, DATA_OUT_VECTOR_ENABLE=0, DATA_OUT=0, OVERFLOW=0, ERROR=0, state IDLE, indices 0.
- RST asserted mid-run: immediate return to reset values; run abandoned, no output.
- START at edge k (legal) → ACCUMULATE from edge k; first element accepted at edge k+1 earliest.
- Illegal START at edge k → ERROR, READY high in cycle after edge k, for exactly one cycle.
- Final input accepted at edge t → element i on DATA_OUT after edge t+1+i; DATA_OUT_VECTOR_ENABLE and READY after edge t+SIZE.
- Total latency for gap-free input: 1 + SIZE·LENGTH + SIZE cycles from START edge to READY.
- Enables and READY are single-cycle pulses; DATA_OUT holds last value outside DRAIN; OVERFLOW holds until next accepted START.
- New START accepted in the cycle READY is high (block is in IDLE).

## Test plan

- SIZE=3, LENGTH=2, inputs 1,2,3,4,5,6 gap-free → DATA_OUT 5,7,9 on three consecutive cycles, VECTOR_ENABLE and READY with 9, OVERFLOW=0.
- SIZE=4, LENGTH=1, inputs 10,-3,0,7 with random enable gaps → outputs 10,-3,0,7; latency from last accepted input exactly 1 cycle to first output.
- DATA_SIZE=8, SATURATE=1: 100+100 → 127, -100+-100 → -128, OVERFLOW=1; SATURATE=0: 100+100 → -56, OVERFLOW=1; 50+50 → 100, OVERFLOW=0.
- START with SIZE_IN=0, SIZE_IN=MAX_SIZE+1, LENGTH_IN=0 → ERROR and READY pulse one cycle, no SCALAR_ENABLE; SIZE_IN=MAX_SIZE, LENGTH=3 of all 1s → MAX_SIZE outputs of 3.
- RST low mid-ACCUMULATE, then new run SIZE=2, LENGTH=2, inputs 1,1,2,2 → outputs 3,3 (no stale data), all outputs at reset values during RST.
- START pulsed during ACCUMULATE/DRAIN → ignored; back-to-back run with START in READY cycle → second run correct and OVERFLOW cleared.
